// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl
// Brief    : Turns an EX-stage taken-branch decision into a one-cycle PC
//            redirect plus a multi-cycle IF/ID + ID/EX flush, with stats.
// Revision : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_branch_valid,
    input  logic              br_sel,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              stall_in,
    input  logic              cnt_clr,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              busy,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  taken_cnt
);

    localparam logic [1:0] c_idle     = 2'd0;
    localparam logic [1:0] c_pend     = 2'd1;
    localparam logic [1:0] c_redirect = 2'd2;
    localparam logic [1:0] c_flush    = 2'd3;

    // REDIRECT supplies the first flush cycle, FLUSH covers the remainder.
    localparam logic [3:0] c_flush_load = 4'(FLUSH_CYCLES - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [3:0]        r_flush_cnt;
    logic [ADDR_W-1:0] r_redirect_pc;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_taken_cnt;
    logic              r_pc_redirect;
    logic              r_flush;
    logic              r_busy;

    logic w_in_idle;
    logic w_count_branch;
    logic w_take;
    logic w_pc_redirect_d;
    logic w_flush_d;
    logic w_busy_d;

    // A stalled not-taken branch is re-presented later, so only unstalled
    // ones count; a stalled taken branch is latched and counted at once.
    assign w_in_idle      = (r_state == c_idle);
    assign w_take         = w_in_idle && ex_branch_valid && br_sel;
    assign w_count_branch = (w_in_idle && ex_branch_valid && !stall_in) || w_take;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (w_take) begin
                    w_next_state = stall_in ? c_pend : c_redirect;
                end
            end
            c_pend: begin
                if (!stall_in) begin
                    w_next_state = c_redirect;
                end
            end
            c_redirect: begin
                w_next_state = (c_flush_load == 4'd0) ? c_idle : c_flush;
            end
            c_flush: begin
                if (!stall_in && (r_flush_cnt == 4'd1)) begin
                    w_next_state = c_idle;
                end
            end
            default: w_next_state = c_idle;
        endcase
    end

    // Outputs are decoded from the next state and registered below.
    always_comb begin
        w_pc_redirect_d = (w_next_state == c_redirect);
        w_flush_d       = (w_next_state == c_redirect) || (w_next_state == c_flush);
        w_busy_d        = (w_next_state != c_idle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc_redirect <= 1'b0;
            r_flush       <= 1'b0;
            r_busy        <= 1'b0;
            r_redirect_pc <= '0;
            r_flush_cnt   <= 4'd0;
            r_branch_cnt  <= '0;
            r_taken_cnt   <= '0;
        end else begin
            r_pc_redirect <= w_pc_redirect_d;
            r_flush       <= w_flush_d;
            r_busy        <= w_busy_d;

            if (w_take) begin
                r_redirect_pc <= ex_target;
            end

            if (r_state == c_redirect) begin
                r_flush_cnt <= c_flush_load;
            end else if ((r_state == c_flush) && !stall_in) begin
                r_flush_cnt <= r_flush_cnt - 4'd1;
            end

            if (cnt_clr) begin
                r_branch_cnt <= '0;
            end else if (w_count_branch && (r_branch_cnt != {CNT_W{1'b1}})) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end

            if (cnt_clr) begin
                r_taken_cnt <= '0;
            end else if (w_take && (r_taken_cnt != {CNT_W{1'b1}})) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_redirect = r_pc_redirect;
    assign redirect_pc = r_redirect_pc;
    assign flush_if_id = r_flush;
    assign flush_id_ex = r_flush;
    assign busy        = r_busy;
    assign branch_cnt  = r_branch_cnt;
    assign taken_cnt   = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_redirect_ctrl
// Brief    : Directed self-checking bench for branch_redirect_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_branch_valid = 1'b0;
    logic        br_sel = 1'b0;
    logic [31:0] ex_target = 32'h0;
    logic        stall_in = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        busy;
    logic [15:0] branch_cnt;
    logic [15:0] taken_cnt;

    // Second instance: 2-bit counters, single-cycle flush.
    logic        s_valid = 1'b0;
    logic        s_br_sel = 1'b0;
    logic [31:0] s_target = 32'h0;
    logic        s_stall = 1'b0;
    logic        s_clr = 1'b0;
    logic        s_pc_redirect;
    logic [31:0] s_redirect_pc;
    logic        s_flush_if_id;
    logic        s_flush_id_ex;
    logic        s_busy;
    logic [1:0]  s_branch_cnt;
    logic [1:0]  s_taken_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .ex_branch_valid(ex_branch_valid), .br_sel(br_sel),
        .ex_target(ex_target), .stall_in(stall_in), .cnt_clr(cnt_clr),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .busy(busy), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    branch_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(1), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .ex_branch_valid(s_valid), .br_sel(s_br_sel),
        .ex_target(s_target), .stall_in(s_stall), .cnt_clr(s_clr),
        .pc_redirect(s_pc_redirect), .redirect_pc(s_redirect_pc), .flush_if_id(s_flush_if_id),
        .flush_id_ex(s_flush_id_ex), .busy(s_busy), .branch_cnt(s_branch_cnt), .taken_cnt(s_taken_cnt)
    );

    // One clock edge, then settle; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic t, input logic [31:0] tgt, input logic st);
        ex_branch_valid = v;
        br_sel          = t;
        ex_target       = tgt;
        stall_in        = st;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if ({pc_redirect, flush_if_id, flush_id_ex, busy} !== 4'b0000) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", {pc_redirect, flush_if_id, flush_id_ex, busy}); end
        n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", redirect_pc); end
        n_cmp++; if ({branch_cnt, taken_cnt} !== 32'h0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", branch_cnt, taken_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_not_taken();
        present(1'b1, 1'b0, 32'h44, 1'b0);
        step();
        present(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if (branch_cnt !== 16'd1 || taken_cnt !== 16'd0) begin n_err++; $display("FAIL nt_cnt: got %0d/%0d want 1/0", branch_cnt, taken_cnt); end
        n_cmp++; if ({pc_redirect, flush_if_id, flush_id_ex, busy} !== 4'b0000) begin n_err++; $display("FAIL nt_ctrl: got %b want 0000", {pc_redirect, flush_if_id, flush_id_ex, busy}); end
        step();
        n_cmp++; if ({pc_redirect, flush_if_id, redirect_pc} !== {2'b00, 32'h0}) begin n_err++; $display("FAIL nt_after: got %b %b %h want 0 0 0", pc_redirect, flush_if_id, redirect_pc); end
    endtask

    task automatic test_taken();
        present(1'b1, 1'b1, 32'h40, 1'b0);
        step();
        present(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if ({pc_redirect, flush_if_id, flush_id_ex, busy} !== 4'b1111) begin n_err++; $display("FAIL tk_t1_ctrl: got %b want 1111", {pc_redirect, flush_if_id, flush_id_ex, busy}); end
        n_cmp++; if (redirect_pc !== 32'h40) begin n_err++; $display("FAIL tk_pc: got %h want 40", redirect_pc); end
        n_cmp++; if (branch_cnt !== 16'd2 || taken_cnt !== 16'd1) begin n_err++; $display("FAIL tk_cnt: got %0d/%0d want 2/1", branch_cnt, taken_cnt); end
        step();
        n_cmp++; if ({pc_redirect, flush_if_id, flush_id_ex, busy} !== 4'b0111) begin n_err++; $display("FAIL tk_t2_ctrl: got %b want 0111", {pc_redirect, flush_if_id, flush_id_ex, busy}); end
        step();
        n_cmp++; if ({pc_redirect, flush_if_id, flush_id_ex, busy} !== 4'b0000) begin n_err++; $display("FAIL tk_t3_ctrl: got %b want 0000", {pc_redirect, flush_if_id, flush_id_ex, busy}); end
    endtask

    task automatic test_masking();
        present(1'b1, 1'b1, 32'h40, 1'b0);
        step();
        present(1'b1, 1'b1, 32'h80, 1'b0);
        step();
        n_cmp++; if ({pc_redirect, flush_if_id} !== 2'b01) begin n_err++; $display("FAIL mask_t2: got %b want 01", {pc_redirect, flush_if_id}); end
        step();
        present(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if (redirect_pc !== 32'h40) begin n_err++; $display("FAIL mask_pc: got %h want 40", redirect_pc); end
        n_cmp++; if (branch_cnt !== 16'd3 || taken_cnt !== 16'd2) begin n_err++; $display("FAIL mask_cnt: got %0d/%0d want 3/2", branch_cnt, taken_cnt); end
        n_cmp++; if ({pc_redirect, flush_if_id, busy} !== 3'b000) begin n_err++; $display("FAIL mask_t3: got %b want 000", {pc_redirect, flush_if_id, busy}); end
    endtask

    task automatic test_stall_taken();
        present(1'b1, 1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if ({pc_redirect, flush_if_id, busy} !== 3'b001) begin n_err++; $display("FAIL pend_ctrl[%0d]: got %b want 001", i, {pc_redirect, flush_if_id, busy}); end
        end
        n_cmp++; if (branch_cnt !== 16'd4 || taken_cnt !== 16'd3) begin n_err++; $display("FAIL pend_cnt: got %0d/%0d want 4/3", branch_cnt, taken_cnt); end
        stall_in = 1'b0;
        step();
        present(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if ({pc_redirect, flush_if_id, flush_id_ex} !== 3'b111 || redirect_pc !== 32'h100) begin n_err++; $display("FAIL pend_redir: got %b pc %h want 111 pc 100", {pc_redirect, flush_if_id, flush_id_ex}, redirect_pc); end
        n_cmp++; if (branch_cnt !== 16'd4 || taken_cnt !== 16'd3) begin n_err++; $display("FAIL pend_cnt_once: got %0d/%0d want 4/3", branch_cnt, taken_cnt); end
        step();
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL pend_idle: got %b want 0", busy); end
    endtask

    task automatic test_flush_stall();
        present(1'b1, 1'b1, 32'h140, 1'b0);
        step();
        present(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        stall_in = 1'b1;
        step();
        n_cmp++; if ({pc_redirect, flush_if_id, flush_id_ex} !== 3'b011) begin n_err++; $display("FAIL fst_t3: got %b want 011", {pc_redirect, flush_if_id, flush_id_ex}); end
        step();
        stall_in = 1'b0;
        n_cmp++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin n_err++; $display("FAIL fst_t4: got %b want 11", {flush_if_id, flush_id_ex}); end
        step();
        n_cmp++; if ({flush_if_id, flush_id_ex, busy} !== 3'b000) begin n_err++; $display("FAIL fst_t5: got %b want 000", {flush_if_id, flush_id_ex, busy}); end
        n_cmp++; if (branch_cnt !== 16'd5 || taken_cnt !== 16'd4) begin n_err++; $display("FAIL fst_cnt: got %0d/%0d want 5/4", branch_cnt, taken_cnt); end
    endtask

    task automatic test_back_to_back();
        present(1'b1, 1'b1, 32'h200, 1'b0);
        step();
        present(1'b1, 1'b1, 32'h300, 1'b0);
        step();
        step();
        n_cmp++; if ({pc_redirect, busy} !== 2'b00) begin n_err++; $display("FAIL b2b_t3: got %b want 00", {pc_redirect, busy}); end
        step();
        present(1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++; if (pc_redirect !== 1'b1 || redirect_pc !== 32'h300) begin n_err++; $display("FAIL b2b_t4: got %b pc %h want 1 pc 300", pc_redirect, redirect_pc); end
        n_cmp++; if (branch_cnt !== 16'd7 || taken_cnt !== 16'd6) begin n_err++; $display("FAIL b2b_cnt: got %0d/%0d want 7/6", branch_cnt, taken_cnt); end
        step();
        step();
    endtask

    task automatic test_cnt_clr();
        present(1'b1, 1'b1, 32'h400, 1'b0);
        cnt_clr = 1'b1;
        step();
        present(1'b0, 1'b0, 32'h0, 1'b0);
        cnt_clr = 1'b0;
        n_cmp++; if (branch_cnt !== 16'd0 || taken_cnt !== 16'd0) begin n_err++; $display("FAIL clr_cnt: got %0d/%0d want 0/0", branch_cnt, taken_cnt); end
        n_cmp++; if (pc_redirect !== 1'b1 || redirect_pc !== 32'h400) begin n_err++; $display("FAIL clr_redir: got %b pc %h want 1 pc 400", pc_redirect, redirect_pc); end
        step();
        step();
    endtask

    task automatic test_reset_mid_flush();
        present(1'b1, 1'b1, 32'h500, 1'b0);
        step();
        present(1'b0, 1'b0, 32'h0, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_cmp++; if ({pc_redirect, flush_if_id, flush_id_ex, busy} !== 4'b0000) begin n_err++; $display("FAIL rmf_ctrl: got %b want 0000", {pc_redirect, flush_if_id, flush_id_ex, busy}); end
        n_cmp++; if (redirect_pc !== 32'h0 || branch_cnt !== 16'd0 || taken_cnt !== 16'd0) begin n_err++; $display("FAIL rmf_data: got pc %h cnt %0d/%0d want 0 0/0", redirect_pc, branch_cnt, taken_cnt); end
        step();
        n_cmp++; if ({pc_redirect, flush_if_id, busy} !== 3'b000) begin n_err++; $display("FAIL rmf_after: got %b want 000", {pc_redirect, flush_if_id, busy}); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            s_valid  = 1'b1;
            s_br_sel = 1'b1;
            s_target = 32'h600 + 32'(i * 4);
            step();
            s_valid  = 1'b0;
            s_br_sel = 1'b0;
            n_cmp++; if ({s_pc_redirect, s_flush_if_id, s_flush_id_ex} !== 3'b111) begin n_err++; $display("FAIL sat_redir[%0d]: got %b want 111", i, {s_pc_redirect, s_flush_if_id, s_flush_id_ex}); end
            step();
            n_cmp++; if ({s_pc_redirect, s_flush_if_id, s_busy} !== 3'b000) begin n_err++; $display("FAIL sat_fc1[%0d]: got %b want 000", i, {s_pc_redirect, s_flush_if_id, s_busy}); end
        end
        n_cmp++; if (s_taken_cnt !== 2'd3 || s_branch_cnt !== 2'd3) begin n_err++; $display("FAIL sat_cnt: got %0d/%0d want 3/3", s_branch_cnt, s_taken_cnt); end
        n_cmp++; if (s_redirect_pc !== 32'h610) begin n_err++; $display("FAIL sat_pc: got %h want 610", s_redirect_pc); end
        s_valid  = 1'b1;
        s_br_sel = 1'b0;
        s_clr    = 1'b1;
        step();
        s_valid  = 1'b0;
        s_clr    = 1'b0;
        n_cmp++; if (s_taken_cnt !== 2'd0 || s_branch_cnt !== 2'd0) begin n_err++; $display("FAIL sat_clr: got %0d/%0d want 0/0", s_branch_cnt, s_taken_cnt); end
    endtask

    initial begin
        test_reset();
        test_not_taken();
        test_taken();
        test_masking();
        test_stall_taken();
        test_flush_stall();
        test_back_to_back();
        test_cnt_clr();
        test_reset_mid_flush();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
